multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle opcode decoder with a state machine that moves each instruction through fetch, decode, execute, memory and writeback over several cycles. The same ALU, register file and memory port are reused in each step. It sits between the instruction register (opcode source), the branch comparator and the shared instruction/data memory port, and drives every datapath mux select and write enable.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I sequencer.
//   - state_t   : 4-bit FSM state encoding (also exported on the debug port)
//   - OP_*      : RV32I major opcodes recognised by DECODE
//   - ALU_*, SRCA_*, SRCB_*, M2R_* : datapath mux / ALU control encodings
//   - ctrl_t    : bundle of every control output driven by the sequencer
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC4    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] mem_to_reg;
    logic       pc_src;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: sequencer <-> datapath signal bundle.
//   master (sequencer): in  opcode[7], br_taken, mem_ready
//                       out pc_write, ir_write, mem_read, mem_write, reg_write,
//                           alu_src_a[2], alu_src_b[2], aluop[2], mem_to_reg[2],
//                           pc_src, fault, state[4]
//   slave  (datapath/memory side): the mirror image.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic [1:0] mem_to_reg;
  logic       pc_src;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  opcode, br_taken, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, aluop, mem_to_reg, pc_src, fault, state
  );

  modport slave (
    output opcode, br_taken, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, aluop, mem_to_reg, pc_src, fault, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 8-bit memory wait counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (asserted on every state change)
//   tick       : a memory state is waiting this cycle (mem_ready low)
//   expired    : this wait cycle is the TIMEOUT_CYCLES-th in a row
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  // count holds the waits already seen, so the current one is the last allowed
  assign expired = tick && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32I datapath.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_ctrl_if.master (opcode/br_taken/mem_ready in,
//           mux selects, write enables, fault and debug state out)
// Build option: define CTRL_TIMEOUT_EN to fault after TIMEOUT_CYCLES
// consecutive memory wait cycles; otherwise memory states wait forever.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  multicycle_ctrl_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_o;
  logic   run;
  logic   expired;

  // run is low during reset and until the first edge after release, which
  // blanks every output and freezes the FSM in FETCH for that window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      state_q <= S_FETCH;
    end else begin
      run <= 1'b1;
      if (run) state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.aluop     = ALU_ADD;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
        else if (expired)  state_d = S_FAULT;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALU_ADD;
        case (bus.opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.aluop     = ALU_FUNCT;
        state_d        = S_WB_ALU;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALU_FUNCT;
        state_d        = S_WB_ALU;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        state_d         = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALU_ADD;
        state_d        = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
        else if (expired)  state_d = S_FAULT;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else if (expired)  state_d = S_FAULT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.aluop     = ALU_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = bus.br_taken;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC4;
        ctrl.pc_src     = 1'b1;
        ctrl.pc_write   = 1'b1;
        state_d         = S_FETCH;
      end
      S_JALR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.aluop      = ALU_ADD;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC4;
        state_d         = S_FETCH;
      end
      S_FAULT: begin
        ctrl.fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

`ifdef CTRL_TIMEOUT_EN
  logic tick, clear;

  assign tick  = run && !bus.mem_ready &&
                 (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR);
  // any state change is an entry into a new state, so clearing on change
  // restarts the count for every memory access
  assign clear = !run || (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .tick   (tick),
    .expired(expired)
  );
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign expired        = 1'b0;
`endif

  assign ctrl_o = run ? ctrl : '0;

  assign bus.pc_write   = ctrl_o.pc_write;
  assign bus.ir_write   = ctrl_o.ir_write;
  assign bus.mem_read   = ctrl_o.mem_read;
  assign bus.mem_write  = ctrl_o.mem_write;
  assign bus.reg_write  = ctrl_o.reg_write;
  assign bus.alu_src_a  = ctrl_o.alu_src_a;
  assign bus.alu_src_b  = ctrl_o.alu_src_b;
  assign bus.aluop      = ctrl_o.aluop;
  assign bus.mem_to_reg = ctrl_o.mem_to_reg;
  assign bus.pc_src     = ctrl_o.pc_src;
  assign bus.fault      = ctrl_o.fault;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level reference traces for multicycle_ctrl.
// Each instruction is expanded into its expected per-cycle output trace
// (state, enables, selects) from opcode, branch outcome and memory wait
// counts; the DUT is driven and compared cycle by cycle.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int TMO = 4;
`ifdef CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          mr;
    bit          br;
    logic [18:0] vec;
  } step_t;

  step_t      tr[$];
  bit         needs_rst;
  logic [6:0] cur_op;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] pk(input logic [3:0] st, input bit pcw, input bit irw,
                                     input bit mrd, input bit mwr, input bit rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] m2r,
                                     input bit ps, input bit flt);
    return {pcw, irw, mrd, mwr, rw, a, b, op, m2r, ps, flt, st};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.mem_to_reg, bus.pc_src,
            bus.fault, bus.state};
  endfunction

  task automatic add(input bit mr, input logic [18:0] v);
    step_t s;
    s.mr  = mr;
    s.br  = 1'($urandom_range(0, 1));
    s.vec = v;
    tr.push_back(s);
  endtask

  function automatic logic [18:0] vmem(input state_t st, input bit mr);
    case (st)
      S_FETCH:  return pk(st, mr, mr, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0);
      S_MEM_RD: return pk(st, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      default:  return pk(st, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endcase
  endfunction

  // w wait cycles then a ready cycle; with the timeout built in, TMO waits
  // in a row end in FAULT, which then holds for 20 cycles
  task automatic add_wait(input state_t st, input int w, output bit ok);
    int n;
    n = (TMO_EN && w >= TMO) ? TMO : w;
    for (int i = 0; i < n; i++) add(1'b0, vmem(st, 1'b0));
    if (TMO_EN && w >= TMO) begin
      for (int i = 0; i < 20; i++)
        add(1'($urandom_range(0, 1)), pk(S_FAULT, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
      needs_rst = 1'b1;
      ok = 1'b0;
    end else begin
      add(1'b1, vmem(st, 1'b1));
      ok = 1'b1;
    end
  endtask

  task automatic build(input logic [6:0] opc, input bit br, input int wf, input int wm);
    bit ok;
    tr.delete();
    needs_rst = 1'b0;
    cur_op    = opc;
    add_wait(S_FETCH, wf, ok);
    if (!ok) return;
    add(1'($urandom_range(0, 1)), pk(S_DECODE, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0));
    case (opc)
      OP_R: begin
        add(1'($urandom_range(0, 1)), pk(S_EXEC_R, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b00, 0, 0));
        add(1'($urandom_range(0, 1)), pk(S_WB_ALU, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
      end
      OP_I: begin
        add(1'($urandom_range(0, 1)), pk(S_EXEC_I, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0, 0));
        add(1'($urandom_range(0, 1)), pk(S_WB_ALU, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
      end
      OP_LOAD: begin
        add(1'($urandom_range(0, 1)), pk(S_MEM_ADDR, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0));
        add_wait(S_MEM_RD, wm, ok);
        if (ok) add(1'($urandom_range(0, 1)), pk(S_WB_MEM, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0));
      end
      OP_STORE: begin
        add(1'($urandom_range(0, 1)), pk(S_MEM_ADDR, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0));
        add_wait(S_MEM_WR, wm, ok);
      end
      OP_BR: begin
        add(1'($urandom_range(0, 1)), pk(S_BRANCH, br, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 1, 0));
        tr[tr.size()-1].br = br;
      end
      OP_JAL:
        add(1'($urandom_range(0, 1)), pk(S_JAL, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b10, 1, 0));
      OP_JALR:
        add(1'($urandom_range(0, 1)), pk(S_JALR, 1, 0, 0, 0, 1, 2'b01, 2'b10, 2'b00, 2'b10, 0, 0));
      default: begin
        for (int i = 0; i < 20; i++)
          add(1'($urandom_range(0, 1)), pk(S_FAULT, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        needs_rst = 1'b1;
      end
    endcase
  endtask

  task automatic run_trace(input string tag, input int limit);
    int n;
    n = (limit < tr.size()) ? limit : tr.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.opcode    = cur_op;
      bus.br_taken  = tr[i].br;
      bus.mem_ready = tr[i].mr;
      #1;
      check($sformatf("%s_c%0d", tag, i + 1), 32'(observed()), 32'(tr[i].vec));
    end
  endtask

  // called 1ns after a negedge: asserts reset mid-cycle, releases it
  // mid-cycle later, and expects every output low until the next edge
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check({tag, "_rst"}, 32'(observed()),
          32'(pk(S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0)));
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check({tag, "_rel"}, 32'(observed()),
          32'(pk(S_FETCH, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0)));
  endtask

  task automatic instr(input string tag, input logic [6:0] opc, input bit br,
                       input int wf, input int wm);
    build(opc, br, wf, wm);
    run_trace(tag, tr.size());
    if (needs_rst) begin
      @(negedge clk);
      #1;
      do_reset(tag);
    end
  endtask

  logic [6:0] ops[9];

  initial begin
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, 7'b1111111, 7'b0000000};
    rst_n         = 1'b1;
    bus.opcode    = 7'd0;
    bus.br_taken  = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    do_reset("init");

    instr("r",      OP_R,     0, 0, 0);
    instr("ld_w3",  OP_LOAD,  0, 0, 3);
    instr("br_t",   OP_BR,    1, 0, 0);
    instr("br_nt",  OP_BR,    0, 0, 0);
    instr("i",      OP_I,     0, 1, 0);
    instr("st",     OP_STORE, 0, 0, 0);
    instr("jal",    OP_JAL,   0, 2, 0);
    instr("jalr",   OP_JALR,  0, 0, 0);
    instr("ill",    7'b1111111, 0, 0, 0);
    instr("f_w4",   OP_R,     0, 4, 0);
    instr("f_w3",   OP_R,     0, 3, 0);
    instr("ld_w4",  OP_LOAD,  0, 0, 4);
    instr("st_w5",  OP_STORE, 0, 0, 5);
    instr("f_w300", OP_I,     0, 300, 0);

    // reset while a store is waiting in MEM_WR
    build(OP_STORE, 0, 0, 3);
    run_trace("st_abort", 5);
    do_reset("st_abort");
    instr("after_abort", OP_R, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      instr($sformatf("rnd%0d", k), ops[$urandom_range(0, 8)],
            1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
